// File: rtl/gcm_block_packer_if.sv
// Beat-in / word-out signal bundle between the packet source, the packer and the cipher.
// The packer sits on the slave modport; the beat source drives through the master modport.
interface gcm_block_packer_if #(
    parameter int NB_BLOCK  = 128,
    parameter int N_BLOCKS  = 2,
    parameter int NB_LENGTH = 64,
    parameter int NB_GAP    = 8
);
    localparam int NB_DATA = N_BLOCKS * NB_BLOCK;

    logic [NB_BLOCK-1:0]  i_block;
    logic                 i_block_valid;
    logic                 i_block_first;
    logic                 i_block_last;
    logic [4:0]           i_block_bytes;
    logic [NB_GAP-1:0]    i_rf_static_gap;
    logic                 i_clear_fault_flags;
    logic                 o_ready;
    logic [NB_DATA-1:0]   o_plaintext_words_x;
    logic                 o_valid_text;
    logic                 o_sop;
    logic                 o_eop;
    logic [NB_LENGTH-1:0] o_length_plaintext;
    logic                 o_fault_protocol;

    modport master (
        output i_block, i_block_valid, i_block_first, i_block_last, i_block_bytes,
               i_rf_static_gap, i_clear_fault_flags,
        input  o_ready, o_plaintext_words_x, o_valid_text, o_sop, o_eop,
               o_length_plaintext, o_fault_protocol
    );

    modport slave (
        input  i_block, i_block_valid, i_block_first, i_block_last, i_block_bytes,
               i_rf_static_gap, i_clear_fault_flags,
        output o_ready, o_plaintext_words_x, o_valid_text, o_sop, o_eop,
               o_length_plaintext, o_fault_protocol
    );
endinterface

// File: rtl/gcm_block_packer.sv
// Packs 128-bit plaintext beats into N_BLOCKS-wide cipher words with sop/eop/length framing.
// sop 1 cycle after the first beat, words 2 cycles after the completing beat; ready drops for gap+1 cycles after each last beat.
module gcm_block_packer #(
    parameter int NB_BLOCK  = 128,
    parameter int N_BLOCKS  = 2,
    parameter int NB_DATA   = N_BLOCKS * NB_BLOCK,
    parameter int NB_LENGTH = 64,
    parameter int NB_GAP    = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    gcm_block_packer_if.slave bus
);
    localparam int                 NB_BYTES   = NB_BLOCK / 8;
    localparam int                 NB_SLOT    = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam logic [4:0]         FULL_BYTES = 5'(NB_BYTES);
    localparam logic [NB_SLOT-1:0] LAST_SLOT  = NB_SLOT'(N_BLOCKS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_GAP} state_t;

    state_t               state_q;
    logic                 ready_q;
    logic [NB_GAP-1:0]    gap_cnt_q;
    logic [NB_SLOT-1:0]   slot_q;
    logic [NB_DATA-1:0]   acc_q;
    logic [NB_LENGTH-1:0] len_q;
    logic                 s1_vld_q;
    logic                 s1_eop_q;
    logic [NB_DATA-1:0]   s1_word_q;
    logic [NB_LENGTH-1:0] s1_len_q;
    logic                 out_vld_q;
    logic                 out_eop_q;
    logic                 sop_q;
    logic                 fault_q;
    logic [NB_DATA-1:0]   out_word_q;
    logic [NB_LENGTH-1:0] out_len_q;

    logic                 take;
    logic                 start;
    logic                 beat;
    logic                 fault_evt;
    logic                 complete;
    logic [4:0]           eff_bytes;
    logic [NB_SLOT-1:0]   slot_cur;
    logic [NB_BLOCK-1:0]  masked;
    logic [NB_DATA-1:0]   word_next;
    logic [NB_LENGTH-1:0] len_next;

    assign take  = bus.i_block_valid & ready_q;
    assign start = take & bus.i_block_first;
    // A first beat is always packed, even mid-packet: it restarts framing and drops the partial word.
    assign beat  = start | (take & (state_q == ST_PACK));
    assign fault_evt = (bus.i_block_valid & ~ready_q)
                     | (take & (state_q == ST_IDLE) & ~bus.i_block_first)
                     | (take & (state_q == ST_PACK) &  bus.i_block_first);

    assign eff_bytes = ((bus.i_block_bytes == 5'd0) || (bus.i_block_bytes >= FULL_BYTES))
                     ? FULL_BYTES : bus.i_block_bytes;
    assign slot_cur  = bus.i_block_first ? '0 : slot_q;
    assign complete  = bus.i_block_last | (slot_cur == LAST_SLOT);

    always_comb begin
        masked = bus.i_block;
        if (bus.i_block_last) begin
            for (int j = 0; j < NB_BYTES; j++) begin
                if (5'(j) >= eff_bytes) masked[NB_BLOCK-1-8*j -: 8] = 8'h00;
            end
        end
        word_next = bus.i_block_first ? '0 : acc_q;
        word_next[slot_cur*NB_BLOCK +: NB_BLOCK] = masked;
        len_next = (bus.i_block_first ? '0 : len_q)
                 + (bus.i_block_last ? (NB_LENGTH'(eff_bytes) << 3) : NB_LENGTH'(NB_BLOCK));
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            gap_cnt_q  <= '0;
            slot_q     <= '0;
            acc_q      <= '0;
            len_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_word_q  <= '0;
            s1_len_q   <= '0;
            out_vld_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            sop_q      <= 1'b0;
            fault_q    <= 1'b0;
            out_word_q <= '0;
            out_len_q  <= '0;
        end else begin
            sop_q <= start;

            case (state_q)
                ST_IDLE, ST_PACK: begin
                    if (beat && bus.i_block_last) begin
                        state_q   <= ST_GAP;
                        ready_q   <= 1'b0;
                        gap_cnt_q <= bus.i_rf_static_gap;
                    end else if (start) begin
                        state_q <= ST_PACK;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase

            if (beat) begin
                len_q <= len_next;
                if (complete) begin
                    s1_word_q <= word_next;
                    acc_q     <= '0;
                    slot_q    <= '0;
                end else begin
                    acc_q  <= word_next;
                    slot_q <= slot_cur + 1'b1;
                end
                if (bus.i_block_last) s1_len_q <= len_next;
            end
            s1_vld_q <= beat & complete;
            s1_eop_q <= beat & bus.i_block_last;

            // Second pipeline stage: word and length hold between pulses.
            out_vld_q <= s1_vld_q;
            out_eop_q <= s1_eop_q;
            if (s1_vld_q) out_word_q <= s1_word_q;
            if (s1_eop_q) out_len_q  <= s1_len_q;

            if (fault_evt)                    fault_q <= 1'b1;
            else if (bus.i_clear_fault_flags) fault_q <= 1'b0;
        end
    end

    assign bus.o_ready             = ready_q;
    assign bus.o_plaintext_words_x = out_word_q;
    assign bus.o_valid_text        = out_vld_q;
    assign bus.o_sop               = sop_q;
    assign bus.o_eop               = out_eop_q;
    assign bus.o_length_plaintext  = out_len_q;
    assign bus.o_fault_protocol    = fault_q;
endmodule

// File: tb/tb_gcm_block_packer.sv
// Randomized bench for gcm_block_packer against a packet-level timing model plus literal test-plan vectors.
module tb_gcm_block_packer;
    localparam int NB_BLOCK  = 128;
    localparam int N_BLOCKS  = 2;
    localparam int NB_DATA   = N_BLOCKS * NB_BLOCK;
    localparam int NB_LENGTH = 64;
    localparam int NB_GAP    = 8;
    localparam int MAXE      = 8192;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gcm_block_packer_if #(.NB_BLOCK(NB_BLOCK), .N_BLOCKS(N_BLOCKS),
                          .NB_LENGTH(NB_LENGTH), .NB_GAP(NB_GAP)) bus ();

    gcm_block_packer #(.NB_BLOCK(NB_BLOCK), .N_BLOCKS(N_BLOCKS), .NB_DATA(NB_DATA),
                       .NB_LENGTH(NB_LENGTH), .NB_GAP(NB_GAP)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Expectations indexed by the clock edge after which the output is visible.
    bit                   exp_sop [MAXE];
    bit                   exp_vld [MAXE];
    bit                   exp_eop [MAXE];
    bit                   exp_rdy [MAXE];
    bit                   f_set   [MAXE];
    bit                   f_clr   [MAXE];
    logic [NB_DATA-1:0]   exp_word[MAXE];
    logic [NB_LENGTH-1:0] exp_len [MAXE];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    logic [NB_DATA-1:0]   cur_word = '0;
    logic [NB_LENGTH-1:0] cur_len = '0;
    bit                   cur_fault = 1'b0;
    logic [NB_DATA-1:0]   got_q[$];
    logic [NB_BLOCK-1:0]  pkt[$];
    int ready_edge = 0;
    bit in_packet = 1'b0;

    task automatic chk(string nm, logic [NB_DATA-1:0] act, logic [NB_DATA-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, edge_n);
        end
    endtask

    always @(negedge clk) begin : cmp
        int w;
        w = edge_n;
        if (chk_en && w < MAXE) begin
            if (f_set[w])      cur_fault = 1'b1;
            else if (f_clr[w]) cur_fault = 1'b0;
            if (exp_vld[w]) cur_word = exp_word[w];
            if (exp_eop[w]) cur_len  = exp_len[w];
            chk("valid_text", NB_DATA'(bus.o_valid_text), NB_DATA'(exp_vld[w]));
            chk("sop",        NB_DATA'(bus.o_sop),        NB_DATA'(exp_sop[w]));
            chk("eop",        NB_DATA'(bus.o_eop),        NB_DATA'(exp_eop[w]));
            chk("ready",      NB_DATA'(bus.o_ready),      NB_DATA'(exp_rdy[w]));
            chk("fault",      NB_DATA'(bus.o_fault_protocol), NB_DATA'(cur_fault));
            chk("word",       bus.o_plaintext_words_x,    cur_word);
            chk("length",     NB_DATA'(bus.o_length_plaintext), NB_DATA'(cur_len));
            if (bus.o_valid_text) got_q.push_back(bus.o_plaintext_words_x);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to(int e);
        while (edge_n + 1 < e) step();
    endtask

    function automatic logic [NB_BLOCK-1:0] mask_bytes(logic [NB_BLOCK-1:0] b, int nb);
        for (int j = 0; j < NB_BLOCK/8; j++)
            if (j >= nb) b[NB_BLOCK-1-8*j -: 8] = 8'h00;
        return b;
    endfunction

    task automatic fill_rand(int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Model: the whole packet is grouped into words up front, then timing is scheduled per beat.
    task automatic send_packet(int bytes, int gap, bit abort, int idle_pct);
        int n;
        int nb;
        int e;
        logic [NB_DATA-1:0]   words[$];
        logic [NB_LENGTH-1:0] len;
        logic [NB_DATA-1:0]   wd;
        logic [NB_BLOCK-1:0]  blk;
        bit last;
        n  = pkt.size();
        nb = (bytes == 0 || bytes >= 16) ? 16 : bytes;
        for (int w = 0; w * N_BLOCKS < n; w++) begin
            wd = '0;
            for (int k = 0; k < N_BLOCKS; k++) begin
                if (w * N_BLOCKS + k < n) begin
                    blk = pkt[w * N_BLOCKS + k];
                    if (w * N_BLOCKS + k == n - 1 && !abort) blk = mask_bytes(blk, nb);
                    wd[k*NB_BLOCK +: NB_BLOCK] = blk;
                end
            end
            words.push_back(wd);
        end
        len = NB_LENGTH'(NB_BLOCK * (n - 1) + 8 * nb);
        bus.i_rf_static_gap = NB_GAP'(gap);
        idle_to(ready_edge);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(99) < idle_pct) step();
            e = edge_n + 1;
            last = (i == n - 1) && !abort;
            bus.i_block       = pkt[i];
            bus.i_block_valid = 1'b1;
            bus.i_block_first = (i == 0);
            bus.i_block_last  = last;
            bus.i_block_bytes = last ? 5'(bytes) : 5'($urandom_range(0, 31));
            if (i == 0) begin
                exp_sop[e] = 1'b1;
                if (in_packet) f_set[e] = 1'b1;
            end
            if ((i % N_BLOCKS == N_BLOCKS - 1) || last) begin
                exp_vld[e+1]  = 1'b1;
                exp_word[e+1] = words[i / N_BLOCKS];
            end
            if (last) begin
                exp_eop[e+1] = 1'b1;
                exp_len[e+1] = len;
                for (int g = 0; g <= gap; g++) exp_rdy[e+g] = 1'b0;
                ready_edge = e + gap + 2;
            end
            step();
            bus.i_block_valid = 1'b0;
            bus.i_block_first = 1'b0;
            bus.i_block_last  = 1'b0;
        end
        in_packet = abort;
    endtask

    task automatic stray(bit with_clear);
        int e;
        idle_to(ready_edge);
        e = edge_n + 1;
        bus.i_block_valid = 1'b1;
        bus.i_block_first = 1'b0;
        bus.i_block_last  = 1'($urandom_range(0, 1));
        bus.i_block       = {$urandom, $urandom, $urandom, $urandom};
        f_set[e] = 1'b1;
        if (with_clear) begin
            bus.i_clear_fault_flags = 1'b1;
            f_clr[e] = 1'b1;
        end
        step();
        bus.i_block_valid = 1'b0;
        bus.i_block_last  = 1'b0;
        bus.i_clear_fault_flags = 1'b0;
    endtask

    task automatic gap_poke();
        int e;
        e = edge_n + 1;
        if (e < ready_edge) begin
            bus.i_block_valid = 1'b1;
            bus.i_block_first = 1'b1;
            f_set[e] = 1'b1;
            step();
            bus.i_block_valid = 1'b0;
            bus.i_block_first = 1'b0;
        end
    endtask

    task automatic clear_fault();
        int e;
        e = edge_n + 1;
        bus.i_clear_fault_flags = 1'b1;
        f_clr[e] = 1'b1;
        step();
        bus.i_clear_fault_flags = 1'b0;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_ready"}, NB_DATA'(bus.o_ready), NB_DATA'(1'b1));
        chk({tag, "_valid"}, NB_DATA'(bus.o_valid_text), '0);
        chk({tag, "_sop"},   NB_DATA'(bus.o_sop), '0);
        chk({tag, "_eop"},   NB_DATA'(bus.o_eop), '0);
        chk({tag, "_fault"}, NB_DATA'(bus.o_fault_protocol), '0);
        chk({tag, "_word"},  bus.o_plaintext_words_x, '0);
        chk({tag, "_len"},   NB_DATA'(bus.o_length_plaintext), '0);
    endtask

    initial begin
        int cnt;
        int n;
        int gap;
        bit ab;
        for (int e = 0; e < MAXE; e++) exp_rdy[e] = 1'b1;
        bus.i_block = '0;
        bus.i_block_valid = 1'b0;
        bus.i_block_first = 1'b0;
        bus.i_block_last = 1'b0;
        bus.i_block_bytes = '0;
        bus.i_rf_static_gap = '0;
        bus.i_clear_fault_flags = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // Full blocks
        pkt = '{128'hd9313225f88406e5a55909c5aff5269a, 128'h86a7a9531534f7da2e4c303d8a318a72,
                128'h1c3c0c95956809532fcf0e2449a6b525, 128'hb16aedf5aa0de657ba637b391aafd255};
        got_q.delete();
        send_packet(16, 2, 1'b0, 0);
        repeat (4) step();
        chk("tc15_nwords", NB_DATA'(got_q.size()), NB_DATA'(2));
        if (got_q.size() == 2) begin
            chk("tc15_word0", got_q[0], 256'h86a7a9531534f7da2e4c303d8a318a72d9313225f88406e5a55909c5aff5269a);
            chk("tc15_word1", got_q[1], 256'hb16aedf5aa0de657ba637b391aafd2551c3c0c95956809532fcf0e2449a6b525);
        end
        chk("tc15_len", NB_DATA'(bus.o_length_plaintext), NB_DATA'(64'h200));

        // Partial last block
        got_q.delete();
        send_packet(12, 2, 1'b0, 0);
        repeat (4) step();
        chk("partial_nwords", NB_DATA'(got_q.size()), NB_DATA'(2));
        if (got_q.size() == 2)
            chk("partial_word1", got_q[1], 256'hb16aedf5aa0de657ba637b39000000001c3c0c95956809532fcf0e2449a6b525);
        chk("partial_len", NB_DATA'(bus.o_length_plaintext), NB_DATA'(64'h1e0));

        // Single short block
        pkt = '{128'hd9313225f88406e5a55909c5aff5269a};
        got_q.delete();
        send_packet(5, 1, 1'b0, 0);
        repeat (4) step();
        chk("short_nwords", NB_DATA'(got_q.size()), NB_DATA'(1));
        if (got_q.size() == 1)
            chk("short_word", got_q[0], {128'h0, 128'hd9313225f80000000000000000000000});
        chk("short_len", NB_DATA'(bus.o_length_plaintext), NB_DATA'(64'h28));

        // Gap of 38: ready low for exactly 39 cycles, then back-to-back packet with a poke in its gap
        fill_rand(3);
        send_packet(16, 38, 1'b0, 0);
        cnt = 0;
        while (!bus.o_ready && cnt < 100) begin
            cnt++;
            step();
        end
        chk("gap38_ready_low", NB_DATA'(cnt), NB_DATA'(39));
        fill_rand(2);
        send_packet(9, 38, 1'b0, 0);
        gap_poke();
        chk("gap_poke_fault", NB_DATA'(bus.o_fault_protocol), NB_DATA'(1'b1));
        clear_fault();
        chk("clear_fault", NB_DATA'(bus.o_fault_protocol), '0);

        // Protocol faults
        stray(1'b0);
        chk("stray_fault", NB_DATA'(bus.o_fault_protocol), NB_DATA'(1'b1));
        clear_fault();
        stray(1'b1);
        chk("set_beats_clear", NB_DATA'(bus.o_fault_protocol), NB_DATA'(1'b1));
        clear_fault();
        got_q.delete();
        fill_rand(3);
        send_packet(16, 0, 1'b1, 0);
        fill_rand(2);
        send_packet(16, 0, 1'b0, 0);
        repeat (4) step();
        chk("abort_nwords", NB_DATA'(got_q.size()), NB_DATA'(2));
        chk("abort_fault", NB_DATA'(bus.o_fault_protocol), NB_DATA'(1'b1));
        clear_fault();

        // Reset mid-packet
        fill_rand(1);
        send_packet(16, 0, 1'b1, 0);
        step();
        step();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #2;
        check_reset_values("midrst");
        for (int e = edge_n; e < MAXE; e++) begin
            exp_sop[e] = 1'b0; exp_vld[e] = 1'b0; exp_eop[e] = 1'b0;
            exp_rdy[e] = 1'b1; f_set[e] = 1'b0; f_clr[e] = 1'b0;
        end
        cur_word = '0;
        cur_len = '0;
        cur_fault = 1'b0;
        in_packet = 1'b0;
        ready_edge = 0;
        @(negedge clk) rst_n = 1'b1;
        step();
        chk_en = 1'b1;
        got_q.delete();
        fill_rand(3);
        send_packet(7, 1, 1'b0, 0);
        repeat (4) step();
        chk("post_reset_nwords", NB_DATA'(got_q.size()), NB_DATA'(2));
        chk("post_reset_len", NB_DATA'(bus.o_length_plaintext), NB_DATA'(64'h138));

        // Randomized traffic
        for (int p = 0; p < 40; p++) begin
            n   = $urandom_range(1, 7);
            gap = $urandom_range(0, 6);
            ab  = ($urandom_range(0, 7) == 0);
            fill_rand(n);
            send_packet($urandom_range(0, 31), gap, ab, 25);
            case ($urandom_range(0, 5))
                0: if (!ab) gap_poke();
                1: if (!in_packet) stray(1'($urandom_range(0, 1)));
                2: clear_fault();
                default: ;
            endcase
        end
        repeat (10) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gcm_block_packer.md
# gcm_block_packer

Upstream framing stage for `gcm_aes_cipher`. It accepts a packet as a stream of 128-bit plaintext beats with first/last markers and packs them into `N_BLOCKS`-wide words, first block in the lowest slice. It generates the `sop`, `valid_text` and `length_plaintext` controls the cipher expects, zero-pads the final partial block and word, and enforces a programmable inter-packet gap so the cipher can finish the tag.

## Interface
Parameters:
- `NB_BLOCK`, 128, bits per block/beat
- `N_BLOCKS`, 2, blocks per output word
- `NB_DATA`, `N_BLOCKS*NB_BLOCK`, output word width
- `NB_LENGTH`, 64, length field width (bits count)
- `NB_GAP`, 8, width of gap programming field

Ports:
- `i_clock`  in  1  clock
- `i_reset_n`  in  1  reset, asynchronous, active-low
- `i_block`  in  `NB_BLOCK`  plaintext beat; byte 0 = bits [127:120]
- `i_block_valid`  in  1  beat present
- `i_block_first`  in  1  first beat of packet
- `i_block_last`  in  1  last beat of packet (may coincide with first)
- `i_block_bytes`  in  5  valid bytes in last beat; 0 or 16 means full; ignored when not last
- `i_rf_static_gap`  in  `NB_GAP`  idle cycles forced after each last beat
- `i_clear_fault_flags`  in  1  clears `o_fault_protocol`
- `o_ready`  out  1  beat accepted when `i_block_valid & o_ready`
- `o_plaintext_words_x`  out  `NB_DATA`  packed word, to cipher `i_plaintext_words_x`
- `o_valid_text`  out  1  word valid, one-cycle pulse per word
- `o_sop`  out  1  start-of-packet pulse, to cipher `i_sop`
- `o_eop`  out  1  high with the last word of a packet
- `o_length_plaintext`  out  `NB_LENGTH`  packet length in bits
- `o_fault_protocol`  out  1  sticky protocol-violation flag

## Operation
- Reset values:
  - `o_ready=1`.
  - `o_plaintext_words_x=0`, `o_length_plaintext=0`.
  - `o_valid_text`, `o_sop`, `o_eop` and `o_fault_protocol` are 0.
  - FSM is in IDLE; slot counter and length accumulator are 0.
- States:
  - IDLE (`o_ready=1`): an accepted beat with first=1 starts a packet and goes to PACK.
  - IDLE: an accepted beat with first=0 is dropped and sets the fault flag.
  - PACK (`o_ready=1`): an accepted beat with last=1 goes to GAP.
  - GAP (`o_ready=0`): a down-counter is loaded with `i_rf_static_gap` and moves to IDLE at 0. A gap of 0 returns to IDLE the next cycle.
- Packing:
  - Beat k of a word is written to slice `[k*NB_BLOCK +: NB_BLOCK]`. The slot counter runs 0..`N_BLOCKS-1` and wraps.
  - A word completes when its slot count reaches `N_BLOCKS` or on the last beat. Unfilled slices are zero.
- Partial final block: bytes at index ≥ `i_block_bytes` are forced to zero before packing.
- Length accumulator:
  - Cleared at the first beat.
  - Adds `NB_BLOCK` per non-last beat and `8*bytes` on the last beat (16 if bytes is 0 or ≥16).
  - Arithmetic is modulo 2^`NB_LENGTH`.
  - `o_length_plaintext` is loaded with the final value in the same cycle as `o_eop`, then held until the next packet's `o_eop`.
- Faults (each sets `o_fault_protocol`):
  - first=1 while in PACK: the pending partial word of the old packet is discarded, with no `o_eop`. The beat starts a new packet and gets a new `o_sop`.
  - `i_block_valid` while `o_ready=0`: the beat is ignored.
- `i_clear_fault_flags` clears the fault flag. A simultaneous new fault wins, so the flag stays 1.

## Timing
- First beat accepted at cycle t: `o_sop` is high at t+1, one cycle.
- Word-completing beat at cycle c: `o_valid_text` (and `o_eop` if last) is high at c+2, through a 2-stage output pipeline. `o_sop` therefore always precedes the first `o_valid_text` by at least 1 cycle.
- `o_plaintext_words_x` holds its value until the next word.
- Sustained throughput is one beat per cycle, i.e. one word per `N_BLOCKS` cycles.
- Last beat at cycle c: `o_ready` is low from c+1 for `i_rf_static_gap+1` cycles.
- An async reset mid-packet discards everything and returns to reset values immediately, with no output pulses.

## Test plan
- **Full blocks.** Test Case 15 packet: 4 beats d9313225f88406e5a55909c5aff5269a, 86a7a9531534f7da2e4c303d8a318a72, 1c3c0c95956809532fcf0e2449a6b525, b16aedf5aa0de657ba637b391aafd255; bytes=16. Required: `o_sop` one cycle after beat 1. Two `o_valid_text` words {86a7…8a72, d931…269a} then {b16a…d255, 1c3c…b525}, `o_eop` on the second. `o_length_plaintext`=0x200.
- **Partial last block.** Same packet, last beat b16aedf5aa0de657ba637b39 with bytes=12. Required: second word upper slice b16aedf5aa0de657ba637b3900000000; length=0x1e0.
- **Single short block.** Single beat with first=last=1, bytes=5. Required: `o_sop` at t+1 and `o_valid_text`+`o_eop` at t+2. Upper slice 0; lower slice keeps only bytes 0..4. Length=0x28.
- **Gap and ready.** `i_rf_static_gap`=38, back-to-back packets offered. Required: `o_ready` low exactly 39 cycles after each last beat. A valid beat offered during the gap sets the fault and is ignored.
- **Protocol faults.** Beat with first=0 in IDLE, and a first beat mid-packet. Required: fault set, the old partial word is never emitted, and the new packet is packed and emitted correctly. `i_clear_fault_flags` clears the flag.
- **Reset mid-packet.** `i_reset_n` pulsed low after 1 beat. Required: all outputs return to reset values, and the next packet is framed correctly.
